urng_share_ctrl: RTL and testbench
==================================

// Module: urng_share_ctrl
// PURPOSE
//  Round-robin scheduler that shares one 64-bit LCG uniform RNG between N_REQ noise-channel requesters.
//  Grants one requester at a time, pulses the RNG enable, captures the returned word and routes it to the winner.
//  Also sequences RNG reseeding by pulsing the RNG's active-low reset, and flags a missing RNG response.
//  Sits between the Rx noise-sim channel generators and the shared URNG instance.
// PARAMETERS
//  N_REQ    4   number of requesters (>=2)
//  DW       64  random word width; matches URNG output
//  TIMEOUT  8   WAIT-state cycles allowed for urng_valid before abort (>=2)
// PORTS
//  clk         in   1      system clock, rising edge
//  rstn        in   1      asynchronous active-low reset
//  req         in   N_REQ  level request per channel
//  gnt         out  N_REQ  one-hot grant, 1-cycle pulse
//  rdata       out  DW     captured random word, held until next capture
//  rvalid      out  N_REQ  one-hot delivery strobe, 1-cycle pulse, qualifies rdata
//  reseed      in   1      1-cycle pulse: request RNG reseed
//  clear_err   in   1      clears err_timeout
//  busy        out  1      1 when FSM is not IDLE
//  err_timeout out  1      sticky: RNG failed to answer within TIMEOUT
//  urng_en     out  1      enable to URNG, 1-cycle pulse
//  urng_rstn   out  1      registered active-low reset to URNG
//  urng_data   in   DW     URNG rand_out
//  urng_valid  in   1      URNG rand_out_valid
// BEHAVIOUR
//  Reset (rstn low, async): state=IDLE, gnt=0, rvalid=0, rdata=0, urng_en=0, urng_rstn=0, busy=0,
//   err_timeout=0, reseed_pend=0, last=N_REQ-1 (so req[0] has top priority first). urng_rstn goes 1 first clk after release.
//  FSM states IDLE, ISSUE, WAIT, RESEED; all outputs registered.
//  IDLE: if reseed or reseed_pend -> RESEED (reseed beats requests). Else if |req: winner = first set bit scanning
//   last+1, last+2, ... mod N_REQ; register winner, last<=winner -> ISSUE. Else stay.
//  ISSUE (1 cycle): gnt[winner]=1, urng_en=1 -> WAIT, wait counter cleared.
//  WAIT: urng_en=0. If urng_valid: rdata<=urng_data, rvalid[winner]=1 next cycle -> IDLE.
//   If counter reaches TIMEOUT without urng_valid: err_timeout<=1, no rvalid -> IDLE.
//  RESEED (1 cycle): urng_rstn=0 this cycle, reseed_pend cleared -> IDLE; urng_rstn back to 1 next cycle.
//  Timing: req sampled in IDLE at edge t -> gnt/urng_en high t+1 -> URNG valid t+2 -> rvalid/rdata at t+3 (IDLE at t+3).
//   Back-to-back service: one word per 3 cycles.
//  req is level: a requester holding req is re-arbitrated fairly; it must drop req after gnt to take one word.
//  reseed pulse outside IDLE sets reseed_pend; served at next IDLE after the in-flight word completes.
//  urng_valid outside WAIT ignored. req changes after ISSUE do not cancel the transaction.
//  clear_err clears err_timeout; same-cycle set and clear -> set wins.
//  busy = (state != IDLE). gnt and rvalid never have more than one bit set.
//  rstn assertion mid-transaction aborts immediately; no rvalid is produced for the aborted grant.
// TESTING
//  1 After reset, req=0001 one cycle -> gnt=0001 and urng_en=1 at t+1; urng_data=64'hA5A5_0000_1234_5678
//    valid t+2 -> rvalid=0001, rdata=64'hA5A5_0000_1234_5678 at t+3.
//  2 req=1111 held 15 cycles -> gnt sequence 0001,0010,0100,1000,0001, spaced exactly 3 cycles; one rvalid per gnt.
//  3 req=0010 granted, reseed pulse during WAIT -> rvalid=0010 delivered, then urng_rstn=0 exactly 1 cycle,
//    then a held req=0010 is granted again.
//  4 urng_valid tied 0, req=0100 -> 8 WAIT cycles then err_timeout=1, no rvalid, busy=0;
//    next req=0001 still granted; clear_err pulse -> err_timeout=0.
//  5 rstn low during WAIT -> gnt, rvalid, urng_en, busy = 0 and urng_rstn=0 asynchronously;
//    after release, req=1001 -> gnt=0001 first.
//  6 urng_valid pulsed in IDLE with req=0 -> no rvalid; rdata unchanged.

Source files
------------

// File: rtl/urng_share_ctrl.sv
// urng_share_ctrl: round-robin sharing of one URNG among N_REQ requesters, with reseed sequencing and response timeout
module urng_share_ctrl #(
  parameter int N_REQ   = 4,
  parameter int DW      = 64,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [DW-1:0]    rdata,
  output logic [N_REQ-1:0] rvalid,
  input  logic             reseed,
  input  logic             clear_err,
  output logic             busy,
  output logic             err_timeout,
  output logic             urng_en,
  output logic             urng_rstn,
  input  logic [DW-1:0]    urng_data,
  input  logic             urng_valid
);
  localparam int LW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESEED} state_t;
  state_t        state;
  logic [LW-1:0] last, pick, idx;
  logic [CW-1:0] cnt;
  logic          reseed_pend, tmo;
  assign tmo = cnt == CW'(TIMEOUT - 1);
  always_comb begin
    pick = last;
    idx = last;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = LW'((int'(last) + i) % N_REQ);
      pick = req[idx] ? idx : pick;
    end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      gnt <= '0;
      rvalid <= '0;
      rdata <= '0;
      urng_en <= 1'b0;
      urng_rstn <= 1'b0;
      busy <= 1'b0;
      err_timeout <= 1'b0;
      reseed_pend <= 1'b0;
      last <= LW'(N_REQ - 1);
      cnt <= '0;
    end else begin
      gnt <= '0;
      rvalid <= '0;
      urng_en <= 1'b0;
      urng_rstn <= 1'b1;
      err_timeout <= (state == WAIT && !urng_valid && tmo) || (err_timeout && !clear_err);
      reseed_pend <= (state == RESEED) ? reseed : reseed_pend | (reseed && state != IDLE);
      case (state)
        IDLE:
          if (reseed || reseed_pend) begin
            state <= RESEED;
            busy <= 1'b1;
            urng_rstn <= 1'b0;
          end else if (|req) begin
            state <= ISSUE;
            busy <= 1'b1;
            last <= pick;
            gnt <= N_REQ'(1) << pick;
            urng_en <= 1'b1;
          end
        ISSUE: begin
          state <= WAIT;
          cnt <= '0;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (urng_valid) begin
            rdata <= urng_data;
            rvalid <= N_REQ'(1) << last;
            state <= IDLE;
            busy <= 1'b0;
          end else if (tmo) begin
            state <= IDLE;
            busy <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_urng_share_ctrl.sv
// tb_urng_share_ctrl: directed and randomized checks of urng_share_ctrl against a transaction-level model
module tb_urng_share_ctrl;
  localparam int N = 4;
  localparam int DW = 64;
  localparam int TO = 8;
  logic clk = 0, rstn = 0, reseed = 0, clear_err = 0, urng_valid = 0;
  logic [N-1:0] req = '0;
  logic [DW-1:0] urng_data = '0;
  logic [N-1:0] gnt, rvalid;
  logic [DW-1:0] rdata;
  logic busy, err_timeout, urng_en, urng_rstn;
  int errs = 0, checks = 0;
  urng_share_ctrl #(.N_REQ(N), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .req(req), .gnt(gnt), .rdata(rdata), .rvalid(rvalid),
    .reseed(reseed), .clear_err(clear_err), .busy(busy), .err_timeout(err_timeout),
    .urng_en(urng_en), .urng_rstn(urng_rstn), .urng_data(urng_data), .urng_valid(urng_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  int lat = 0, rcnt = 0;
  bit fix_en = 1, stray = 0;
  logic [63:0] fix_data = '0, stray_data = '0;
  initial forever begin
    @(negedge clk);
    urng_valid = 0;
    urng_data = {$urandom, $urandom};
    if (rcnt > 0) begin
      rcnt--;
      if (rcnt == 0) begin
        urng_valid = 1;
        urng_data = fix_en ? fix_data : {$urandom, $urandom};
      end
    end
    if (urng_en && lat >= 0) rcnt = lat + 1;
    if (stray) begin
      urng_valid = 1;
      urng_data = stray_data;
      stray = 0;
    end
  end
  logic [N-1:0] e_gnt = '0, e_rvalid = '0, tmp;
  logic [63:0] e_rdata = '0;
  bit e_en = 0, e_rstn = 0, e_busy = 0, e_err = 0, m_pend = 0, m_rs = 0, m_set = 0;
  int m_owner = -1, m_age = 0, m_last = N - 1;
  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      e_gnt = '0; e_rvalid = '0; e_rdata = '0; e_en = 0; e_rstn = 0; e_busy = 0; e_err = 0;
      m_pend = 0; m_rs = 0; m_owner = -1; m_age = 0; m_last = N - 1;
    end else begin
      e_gnt = '0; e_rvalid = '0; e_en = 0; e_rstn = 1; m_set = 0;
      if (!e_busy) begin
        if (reseed || m_pend) begin
          m_rs = 1; e_rstn = 0; e_busy = 1;
        end else if (req != 0) begin
          m_owner = -1;
          for (int k = 1; k <= N; k++) begin
            tmp = req >> ((m_last + k) % N);
            if (m_owner < 0 && tmp[0]) m_owner = (m_last + k) % N;
          end
          m_last = m_owner; m_age = 0;
          e_gnt = N'(1) << m_owner; e_en = 1; e_busy = 1;
        end
      end else if (m_rs) begin
        m_rs = 0; m_pend = reseed; e_busy = 0;
      end else begin
        m_pend = m_pend | reseed;
        m_age++;
        if (m_age >= 2 && urng_valid) begin
          e_rdata = urng_data; e_rvalid = N'(1) << m_owner; e_busy = 0; m_owner = -1;
        end else if (m_age - 1 == TO) begin
          m_set = 1; e_busy = 0; m_owner = -1;
        end
      end
      e_err = m_set | (e_err & !clear_err);
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    chk("gnt", gnt, e_gnt);
    chk("rvalid", rvalid, e_rvalid);
    chk("rdata", rdata, e_rdata);
    chk("urng_en", urng_en, e_en);
    chk("urng_rstn", urng_rstn, e_rstn);
    chk("busy", busy, e_busy);
    chk("err_timeout", err_timeout, e_err);
  end
  task automatic do_reset();
    @(negedge clk) rstn = 0;
    repeat (2) @(negedge clk);
    rstn = 1;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 0); chk("rst_rvalid", rvalid, 0); chk("rst_rdata", rdata, 0);
    chk("rst_en", urng_en, 0); chk("rst_urng_rstn", urng_rstn, 0); chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    // single request: grant, RNG word two cycles later, delivery three cycles later
    fix_data = 64'hA5A5_0000_1234_5678; lat = 0; rstn = 1; req = 4'b0001;
    @(posedge clk); #1 chk("t1_gnt", gnt, 4'b0001); chk("t1_en", urng_en, 1); chk("t1_urng_rstn", urng_rstn, 1);
    @(negedge clk) req = 0;
    @(posedge clk); #1 chk("t1_en_off", urng_en, 0);
    @(posedge clk); #1 chk("t1_rvalid", rvalid, 4'b0001); chk("t1_rdata", rdata, 64'hA5A5_0000_1234_5678);
    chk("t1_busy", busy, 0); chk("t1_model_rdata", e_rdata, 64'hA5A5_0000_1234_5678);
    // all requesters held: rotating grants every third cycle
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      chk("t2_gnt", gnt, (i % 3 == 0) ? 4'(1 << ((i / 3) % 4)) : 4'b0);
      chk("t2_rvalid", rvalid, (i % 3 == 2) ? 4'(1 << ((i / 3) % 4)) : 4'b0);
      if (i == 0) chk("t2_model_gnt", e_gnt, 4'b0001);
    end
    @(negedge clk) req = 0;
    repeat (2) @(negedge clk);
    // reseed arriving mid-transaction is served right after delivery
    req = 4'b0010;
    @(posedge clk); #1 chk("t3_gnt", gnt, 4'b0010);
    @(negedge clk);
    @(negedge clk) reseed = 1;
    @(posedge clk); #1 chk("t3_rvalid", rvalid, 4'b0010);
    @(negedge clk) reseed = 0;
    @(posedge clk); #1 chk("t3_rstn_low", urng_rstn, 0); chk("t3_no_gnt", gnt, 0);
    @(posedge clk); #1 chk("t3_rstn_high", urng_rstn, 1); chk("t3_no_gnt2", gnt, 0); chk("t3_idle", busy, 0);
    @(posedge clk); #1 chk("t3_regnt", gnt, 4'b0010);
    @(negedge clk) req = 0;
    repeat (4) @(negedge clk);
    // silent RNG: timeout after TIMEOUT wait cycles, sticky error until cleared
    lat = -1; req = 4'b0100;
    @(posedge clk); #1 chk("t4_gnt", gnt, 4'b0100);
    @(negedge clk) req = 0;
    repeat (8) @(posedge clk);
    #1 chk("t4_err_pre", err_timeout, 0); chk("t4_busy_pre", busy, 1);
    @(posedge clk); #1 chk("t4_err", err_timeout, 1); chk("t4_busy", busy, 0); chk("t4_rvalid", rvalid, 0);
    chk("t4_model_err", e_err, 1);
    @(negedge clk) lat = 0; req = 4'b0001;
    @(posedge clk); #1 chk("t4_gnt2", gnt, 4'b0001);
    @(negedge clk) req = 0;
    repeat (3) @(negedge clk);
    chk("t4_err_held", err_timeout, 1);
    clear_err = 1;
    @(posedge clk); #1 chk("t4_err_clr", err_timeout, 0);
    @(negedge clk) clear_err = 0;
    // async reset while waiting on the RNG
    fix_data = 64'h0123_4567_89AB_CDEF; lat = -1; req = 4'b0001;
    @(posedge clk); #1 chk("t5_gnt", gnt, 4'b0001);
    @(negedge clk) req = 0;
    @(negedge clk) chk("t5_busy", busy, 1);
    rstn = 0;
    #1 chk("t5_gnt0", gnt, 0); chk("t5_rvalid0", rvalid, 0); chk("t5_en0", urng_en, 0);
    chk("t5_busy0", busy, 0); chk("t5_urng_rstn0", urng_rstn, 0);
    @(negedge clk);
    @(negedge clk) rstn = 1; lat = 0; req = 4'b1001;
    @(posedge clk); #1 chk("t5_gnt_first", gnt, 4'b0001); chk("t5_urng_rstn1", urng_rstn, 1);
    @(negedge clk) req = 0;
    repeat (4) @(negedge clk);
    chk("t5_rdata", rdata, 64'h0123_4567_89AB_CDEF);
    // stray RNG valid while idle is ignored
    stray_data = 64'hDEAD_BEEF_DEAD_BEEF; stray = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 chk("t6_rvalid", rvalid, 0);
    end
    chk("t6_rdata", rdata, 64'h0123_4567_89AB_CDEF); chk("t6_busy", busy, 0);
    // randomized traffic, latencies, reseeds, clears and resets
    fix_en = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 799) == 0) begin
        rstn = 0;
        @(negedge clk);
        rstn = 1;
      end
      if ($urandom_range(0, 2) != 0) req = 4'($urandom_range(0, 15));
      reseed = $urandom_range(0, 19) == 0;
      clear_err = $urandom_range(0, 29) == 0;
      lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 9));
      if ($urandom_range(0, 11) == 0) begin
        stray_data = {$urandom, $urandom};
        stray = 1;
      end
    end
    @(negedge clk) req = 0; reseed = 0; clear_err = 0; lat = 0;
    repeat (20) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
